// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the two-port cache arbiter.
package cache_arb_pkg;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RECOVER
    } arb_state_t;

endpackage

// File: rtl/cache_port_arbiter_rr_pick2.sv
// Two-input round-robin pick: a lone request wins outright, a tie goes to
// the port that did not win last time.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Serialises instruction-fetch (port 0) and load/store (port 1) accesses onto
// the single enable/available cache port, with round-robin fairness and a watchdog.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_we,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_we,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_done,
    output logic              cache_enable,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_write,
    output logic [DATA_W-1:0] cache_wdata,
    input  logic [DATA_W-1:0] cache_rdata,
    input  logic              cache_available,
    output logic              busy,
    output logic              grant_id,
    output logic              timeout_err
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t      state;
    arb_state_t      next_state;
    logic            last;
    logic [WD_W-1:0] wd_cnt;
    logic            gnt_valid;
    logic            gnt_id;
    logic            done_any;

    assign done_any = p0_done | p1_done;
    assign busy     = (state != ST_IDLE);

    rr_pick2 u_pick (
        .req       ({p1_req, p0_req}),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // WAIT is left in the cycle the done pulse is visible, so RECOVER follows it.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (gnt_valid) next_state = ST_ISSUE;
            ST_ISSUE:   next_state = ST_WAIT;
            ST_WAIT:    if (done_any) next_state = ST_RECOVER;
            ST_RECOVER: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_enable <= 1'b0;
            cache_addr   <= '0;
            cache_write  <= 1'b0;
            cache_wdata  <= '0;
            grant_id     <= 1'b0;
            last         <= 1'b1;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
        end else begin
            cache_enable <= 1'b0;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
            if (state == ST_IDLE && gnt_valid) begin
                cache_enable <= 1'b1;
                cache_addr   <= gnt_id ? p1_addr  : p0_addr;
                cache_write  <= gnt_id ? p1_we    : p0_we;
                cache_wdata  <= gnt_id ? p1_wdata : p0_wdata;
                grant_id     <= gnt_id;
                last         <= gnt_id;
            end
            if (state == ST_WAIT && cache_available && !done_any) begin
                if (grant_id) begin
                    p1_done <= 1'b1;
                    if (!cache_write) p1_rdata <= cache_rdata;
                end else begin
                    p0_done <= 1'b1;
                    if (!cache_write) p0_rdata <= cache_rdata;
                end
            end
        end
    end

    // The watchdog only flags a stall; the in-flight access is never abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == ST_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT && wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_LAST) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with a small latency-programmable cache model;
// a second instance with a short watchdog exercises the timeout path.
module tb_cache_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p1_req;
    logic [26:0] p0_addr, p1_addr;
    logic        p0_we, p1_we;
    logic [31:0] p0_wdata, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p1_done;
    logic        cache_enable;
    logic [26:0] cache_addr;
    logic        cache_write;
    logic [31:0] cache_wdata;
    logic [31:0] cache_rdata;
    logic        cache_available;
    logic        busy, grant_id, timeout_err;

    logic        w_p0_req, w_p1_req, w_avail;
    logic [31:0] w_p0_rdata, w_p1_rdata, w_cache_wdata;
    logic        w_p0_done, w_p1_done, w_cache_enable, w_cache_write;
    logic [26:0] w_cache_addr;
    logic        w_busy, w_grant_id, w_timeout_err;

    int total;
    int bad;
    int lat;

    logic [31:0] mem [0:255];
    int          cd;
    logic [7:0]  m_idx;
    logic        m_we;

    cache_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_done(p0_done),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_done(p1_done),
        .cache_enable(cache_enable), .cache_addr(cache_addr), .cache_write(cache_write),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_available(cache_available),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    cache_port_arbiter #(.TIMEOUT(16)) dut_wd (
        .clk(clk), .rst_n(rst_n),
        .p0_req(w_p0_req), .p0_addr(p0_addr), .p0_we(1'b0), .p0_wdata(p0_wdata),
        .p0_rdata(w_p0_rdata), .p0_done(w_p0_done),
        .p1_req(w_p1_req), .p1_addr(p1_addr), .p1_we(1'b0), .p1_wdata(p1_wdata),
        .p1_rdata(w_p1_rdata), .p1_done(w_p1_done),
        .cache_enable(w_cache_enable), .cache_addr(w_cache_addr), .cache_write(w_cache_write),
        .cache_wdata(w_cache_wdata), .cache_rdata(cache_rdata), .cache_available(w_avail),
        .busy(w_busy), .grant_id(w_grant_id), .timeout_err(w_timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cache model: available pulses 'lat' cycles after the cycle enable is seen.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEADBEEF;
        mem[12] = 32'hCAFE0001;
        cd = 0;
        m_idx = '0;
        m_we = 1'b0;
        cache_available = 1'b0;
        cache_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cd = 0;
                cache_available = 1'b0;
            end else begin
                if (cache_available) cache_available = 1'b0;
                if (cache_enable) begin
                    cd = lat;
                    m_idx = cache_addr[9:2];
                    m_we = cache_write;
                    if (cache_write) mem[cache_addr[9:2]] = cache_wdata;
                end else if (cd > 0) begin
                    cd = cd - 1;
                    if (cd == 0) begin
                        cache_available = 1'b1;
                        cache_rdata = m_we ? 32'h0 : mem[m_idx];
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        total++;
        if ({busy, cache_enable, cache_write, p0_done, p1_done, grant_id, timeout_err} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b want 0000000",
                     {busy, cache_enable, cache_write, p0_done, p1_done, grant_id, timeout_err});
        end
        total++;
        if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0 || cache_addr !== 27'h0 || cache_wdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: p0_rdata=%h p1_rdata=%h addr=%h wdata=%h want all 0",
                     p0_rdata, p1_rdata, cache_addr, cache_wdata);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_hit();
        lat = 2;
        p0_addr = 27'h0000010;
        p0_we = 1'b0;
        p0_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) begin
                total++;
                if (cache_enable !== 1'b1 || cache_addr !== 27'h0000010 || grant_id !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL hit_issue: en=%b addr=%h gid=%b busy=%b want 1 0000010 0 1",
                             cache_enable, cache_addr, grant_id, busy);
                end
            end
            if (c == 2) begin
                total++;
                if (cache_enable !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL hit_enable_pulse: en=%b want 0", cache_enable);
                end
            end
            total++;
            if (p0_done !== (c == 4) || p1_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL hit_done_c%0d: p0_done=%b p1_done=%b want %b 0", c, p0_done, p1_done, c == 4);
            end
        end
        p0_req = 1'b0;
        total++;
        if (p0_rdata !== 32'hDEADBEEF || p1_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL hit_rdata: p0=%h p1=%h want deadbeef 00000000", p0_rdata, p1_rdata);
        end
        step();
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hit_back_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int exp_ord [4] = '{0, 1, 0, 1};
        int en;
        bit got;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        lat = 2;
        p0_addr = 27'h0000010;
        p1_addr = 27'h0000030;
        p0_we = 1'b0;
        p1_we = 1'b0;
        p0_req = 1'b1;
        p1_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            en = 0;
            got = 1'b0;
            for (int c = 0; c < 20; c++) begin
                step();
                if (cache_enable) en++;
                if (p0_done || p1_done) begin
                    got = 1'b1;
                    break;
                end
            end
            total++;
            if (!got) begin
                bad++;
                $display("[TB] FAIL b2b_timeout_%0d: no done within 20 cycles", t);
            end else begin
                total++;
                if (p0_done !== (exp_ord[t] == 0) || p1_done !== (exp_ord[t] == 1) || grant_id !== 1'(exp_ord[t])) begin
                    bad++;
                    $display("[TB] FAIL b2b_order_%0d: p0_done=%b p1_done=%b gid=%b want port %0d",
                             t, p0_done, p1_done, grant_id, exp_ord[t]);
                end
            end
            total++;
            if (en != 1) begin
                bad++;
                $display("[TB] FAIL b2b_enables_%0d: got %0d enables want 1", t, en);
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        total++;
        if (p0_rdata !== 32'hDEADBEEF || p1_rdata !== 32'hCAFE0001) begin
            bad++;
            $display("[TB] FAIL b2b_rdata: p0=%h p1=%h want deadbeef cafe0001", p0_rdata, p1_rdata);
        end
        step();
        step();
    endtask

    task automatic test_write_then_read();
        bit got;
        lat = 2;
        p1_addr = 27'h0000024;
        p1_we = 1'b1;
        p1_wdata = 32'h12345678;
        p1_req = 1'b1;
        step();
        total++;
        if (cache_enable !== 1'b1 || cache_write !== 1'b1 || cache_wdata !== 32'h12345678 ||
            cache_addr !== 27'h0000024 || grant_id !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wr_issue: en=%b we=%b wdata=%h addr=%h gid=%b want 1 1 12345678 0000024 1",
                     cache_enable, cache_write, cache_wdata, cache_addr, grant_id);
        end
        p1_wdata = 32'hFFFF0000;
        p1_addr = 27'h0000000;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (p1_done) begin
                got = 1'b1;
                break;
            end
        end
        p1_req = 1'b0;
        p1_we = 1'b0;
        total++;
        if (!got || p1_rdata !== 32'hCAFE0001) begin
            bad++;
            $display("[TB] FAIL wr_done_rdata: done=%b p1_rdata=%h want 1 cafe0001", got, p1_rdata);
        end
        p0_addr = 27'h0000024;
        p0_we = 1'b0;
        p0_req = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (p0_done) begin
                got = 1'b1;
                break;
            end
        end
        p0_req = 1'b0;
        total++;
        if (!got || p0_rdata !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL rd_after_wr: done=%b p0_rdata=%h want 1 12345678", got, p0_rdata);
        end
        step();
        step();
    endtask

    task automatic test_miss();
        int avail_c;
        int done_c;
        lat = 40;
        avail_c = -1;
        done_c = -1;
        p0_addr = 27'h0000010;
        p0_we = 1'b0;
        p0_req = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (cache_available && avail_c < 0) avail_c = c;
            if (p0_done) begin
                done_c = c;
                p0_req = 1'b0;
                break;
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL miss_busy_c%0d: busy=%b want 1", c, busy);
            end
        end
        total++;
        if (done_c < 0 || avail_c < 0 || done_c != avail_c + 1) begin
            bad++;
            $display("[TB] FAIL miss_done_timing: avail at %0d done at %0d want done = avail+1", avail_c, done_c);
        end
        total++;
        if (p0_rdata !== 32'hDEADBEEF || timeout_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL miss_result: p0_rdata=%h terr=%b want deadbeef 0", p0_rdata, timeout_err);
        end
        p0_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_timeout();
        w_p0_req = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            total++;
            if (w_timeout_err !== (k >= 18)) begin
                bad++;
                $display("[TB] FAIL wd_err_c%0d: timeout_err=%b want %b", k, w_timeout_err, k >= 18);
            end
        end
        total++;
        if (w_busy !== 1'b1 || w_p0_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wd_still_waiting: busy=%b done=%b want 1 0", w_busy, w_p0_done);
        end
        step();
        w_avail = 1'b1;
        step();
        w_avail = 1'b0;
        total++;
        if (w_p0_done !== 1'b1 || w_timeout_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wd_late_done: done=%b terr=%b want 1 1", w_p0_done, w_timeout_err);
        end
        w_p0_req = 1'b0;
        step();
        step();
        step();
        total++;
        if (w_timeout_err !== 1'b1 || w_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wd_sticky: terr=%b busy=%b want 1 0", w_timeout_err, w_busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit got;
        bit early;
        lat = 10;
        p0_addr = 27'h0000010;
        p0_we = 1'b0;
        p0_req = 1'b1;
        for (int c = 1; c <= 5; c++) step();
        p0_req = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, cache_enable, cache_write, p0_done, p1_done, grant_id, timeout_err} !== 7'b0 ||
            p0_rdata !== 32'h0 || p1_rdata !== 32'h0 || cache_addr !== 27'h0) begin
            bad++;
            $display("[TB] FAIL rst_wait_outputs: flags=%b p0_rdata=%h p1_rdata=%h addr=%h want all 0",
                     {busy, cache_enable, cache_write, p0_done, p1_done, grant_id, timeout_err},
                     p0_rdata, p1_rdata, cache_addr);
        end
        early = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (p0_done || p1_done || busy) early = 1'b1;
        end
        total++;
        if (early) begin
            bad++;
            $display("[TB] FAIL rst_wait_no_done: activity seen during reset = %b want 0", early);
        end
        rst_n = 1'b1;
        lat = 2;
        p1_addr = 27'h0000030;
        p0_req = 1'b1;
        p1_req = 1'b1;
        step();
        total++;
        if (cache_enable !== 1'b1 || grant_id !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_tie_grant: en=%b gid=%b want 1 0", cache_enable, grant_id);
        end
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (p0_done || p1_done) begin
                got = 1'b1;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        total++;
        if (!got || p0_done !== 1'b1 || p1_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_tie_done: got=%b p0_done=%b p1_done=%b want 1 1 0", got, p0_done, p1_done);
        end
        step();
        step();
    endtask

    initial begin
        total = 0;
        bad = 0;
        lat = 2;
        rst_n = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        p0_addr = '0;
        p1_addr = '0;
        p0_we = 1'b0;
        p1_we = 1'b0;
        p0_wdata = '0;
        p1_wdata = '0;
        w_p0_req = 1'b0;
        w_p1_req = 1'b0;
        w_avail = 1'b0;
        test_reset();
        test_read_hit();
        test_back_to_back();
        test_write_then_read();
        test_miss();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
